svpwm_deadtime: RTL and testbench
=================================

# svpwm_deadtime

Gate-drive conditioning stage that sits directly downstream of the SVPWM switching-state generator. It consumes the six complementary switch commands T_1..T_6 and produces six gate signals G_1..G_6. Every turn-on is preceded by a programmable dead time and every gate pulse is held for a minimum on-time. A latched fault path forces all gates off on an external trip or on a shoot-through command.

## Interface
- DEADTIME, 10: both-gates-off interval before any gate turn-on, in CLK cycles; legal 1..255.
- MIN_ON, 4: minimum gate on-time in CLK cycles before a commanded change is honoured; legal 1..255.

- CLK  in  1  system clock; the same clock as the SVPWM generator.
- RST  in  1  reset; synchronous, active-high.
- T_1, T_2, T_3  in  1 each  upper-switch commands for legs A, B, C.
- T_4, T_5, T_6  in  1 each  lower-switch commands for legs A, B, C.
- FAULT  in  1  external trip, level, active-high.
- FAULT_CLR  in  1  one-cycle clear pulse for latched fault and error flags.
- G_1..G_3  out  1 each  upper gate drives for legs A, B, C.
- G_4..G_6  out  1 each  lower gate drives for legs A, B, C.
- FAULT_LATCHED  out  1  sticky trip indicator.
- ST_ERR  out  3  sticky shoot-through flag per leg; bit0 = A, bit1 = B, bit2 = C.

## Operation
- All inputs are registered once (command register) before use.
- Leg request decode, from the registered upper/lower pair:
  - 10 = HIGH
  - 01 = LOW
  - 00 = OFF
  - 11 = shoot-through: request treated as OFF; sets ST_ERR[leg] and FAULT_LATCHED.
- Each leg runs an independent FSM with states OFF, DEAD, HIGH, LOW.
  - OFF: both gates 0. Request HIGH or LOW -> DEAD, load dead counter with DEADTIME.
  - DEAD: both gates 0; counter decrements each cycle.
    - A request change during DEAD updates the target only; the counter is not reloaded.
    - Counter reaches 0: go to the current request (HIGH, LOW or OFF).
  - HIGH: upper gate 1, lower gate 0; on-counter counts up and saturates at MIN_ON.
    - A request different from HIGH is accepted only once on-count >= MIN_ON.
    - Accepted request: to DEAD (for LOW) or to OFF (for OFF).
    - An unaccepted request is re-evaluated every cycle; the command is not latched.
  - LOW: mirror of HIGH with the lower gate driven.
- Fault path:
  - Registered FAULT = 1 or a shoot-through sets FAULT_LATCHED.
  - While FAULT_LATCHED = 1, all legs are forced to OFF, all G = 0, and MIN_ON is ignored.
  - FAULT_CLR clears FAULT_LATCHED and ST_ERR only if registered FAULT = 0 and no leg decodes 11 in that cycle; otherwise it is ignored.
  - After clear, legs restart from OFF, so every turn-on again passes through DEAD.
- Gate outputs are registered, decoded from FSM state.
- Hard invariant: an upper and lower gate of the same leg are never 1 in the same cycle.
- Counters are 8 bits wide. Dead counter: load DEADTIME, end at 0. On-counter saturates at MIN_ON and does not wrap.

## Timing
- Reset: all G = 0, FAULT_LATCHED = 0, ST_ERR = 000, FSMs in OFF, command registers 0, counters 0. RST takes priority over all other inputs.
- Input sampled at edge k: command register updates at k; FSM acts at k+1.
- Gate turn-off: G falls after edge k+1 (two-cycle latency).
- Gate turn-on: G rises after edge k+1+DEADTIME.
- Direct HIGH<->LOW swap (MIN_ON satisfied): both gates 0 for exactly DEADTIME cycles.
- Fault: FAULT high at edge k; all G = 0 and FAULT_LATCHED = 1 after edge k+1.
- Shoot-through: same latency as a fault, counted from the 11 command.
- RST mid-operation: all G = 0 after the RST edge, with no dead-time sequencing.
- Simultaneous events:
  - Fault and a DEAD expiry in the same cycle: fault wins, leg goes to OFF.
  - FAULT_CLR and FAULT high in the same cycle: no clear.

## Test plan
- Reset, then T_1 = 1, T_4 = 0 held: G_1 rises exactly 11 cycles after the command register update; G_4 stays 0.
- Leg A HIGH for 50 cycles, then swap to LOW: G_1 falls 2 cycles after the input change, G_4 rises 10 cycles later, never overlapping G_1.
- Leg B HIGH, LOW request 1 cycle after G_2 rises: G_2 held 4 cycles total, then DEAD for 10 cycles, then G_5 = 1.
- T_3 = T_6 = 1 for 1 cycle: G_3 = G_6 = 0, ST_ERR = 100, FAULT_LATCHED = 1; all gates stay 0 until FAULT_CLR with valid commands.
- FAULT pulse during leg C DEAD, then FAULT_CLR while FAULT still high (ignored), then FAULT_CLR after FAULT drops: flags clear, gates return via a full 10-cycle DEAD.
- Drive a full SVPWM pattern (DEADTIME = 3, MIN_ON = 1) for 2000 cycles: check that no leg ever has both gates high; each gate edge equals the command edge delayed by 2 or by 2 + DEADTIME cycles.

Source files
------------

// File: rtl/svpwm_deadtime.sv
// Dead-time and minimum on-time conditioning for six SVPWM gate drives,
// with a sticky trip path for external faults and shoot-through commands.
module svpwm_deadtime #(
    parameter int unsigned DEADTIME = 10,
    parameter int unsigned MIN_ON   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       T_1,
    input  logic       T_2,
    input  logic       T_3,
    input  logic       T_4,
    input  logic       T_5,
    input  logic       T_6,
    input  logic       FAULT,
    input  logic       FAULT_CLR,
    output logic       G_1,
    output logic       G_2,
    output logic       G_3,
    output logic       G_4,
    output logic       G_5,
    output logic       G_6,
    output logic       FAULT_LATCHED,
    output logic [2:0] ST_ERR
);

    localparam int unsigned CW   = 8;
    localparam int unsigned NLEG = 3;
    localparam logic [CW-1:0] DT_LOAD = CW'(DEADTIME);
    localparam logic [CW-1:0] ON_MIN  = CW'(MIN_ON);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_DEAD = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } leg_state_t;

    logic [NLEG-1:0] up_r;
    logic [NLEG-1:0] lo_r;
    logic            fault_r;
    logic            clr_r;
    logic [NLEG-1:0] shoot;
    logic            fault_set;
    logic            clr_ok;
    logic            force_off;
    logic [NLEG-1:0] gate_hi;
    logic [NLEG-1:0] gate_lo;

    // Command register: every input is sampled once before use.
    always_ff @(posedge CLK) begin
        if (RST) begin
            up_r    <= '0;
            lo_r    <= '0;
            fault_r <= 1'b0;
            clr_r   <= 1'b0;
        end else begin
            up_r    <= {T_3, T_2, T_1};
            lo_r    <= {T_6, T_5, T_4};
            fault_r <= FAULT;
            clr_r   <= FAULT_CLR;
        end
    end

    assign shoot     = up_r & lo_r;
    assign fault_set = fault_r | (|shoot);
    assign clr_ok    = clr_r & ~fault_set;
    assign force_off = FAULT_LATCHED | fault_set;

    // A new trip always beats a clear arriving in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            FAULT_LATCHED <= 1'b0;
            ST_ERR        <= '0;
        end else begin
            if (fault_set) begin
                FAULT_LATCHED <= 1'b1;
            end else if (clr_ok) begin
                FAULT_LATCHED <= 1'b0;
            end
            if (clr_ok) begin
                ST_ERR <= '0;
            end else begin
                ST_ERR <= ST_ERR | shoot;
            end
        end
    end

    for (genvar l = 0; l < NLEG; l++) begin : g_leg
        leg_state_t    state;
        leg_state_t    state_n;
        logic [CW-1:0] dead_cnt;
        logic [CW-1:0] dead_cnt_n;
        logic [CW-1:0] on_cnt;
        logic [CW-1:0] on_cnt_n;
        logic          req_hi;
        logic          req_lo;
        logic          hi_q;
        logic          lo_q;

        assign req_hi = up_r[l] & ~lo_r[l];
        assign req_lo = lo_r[l] & ~up_r[l];

        // Leg sequencer: every turn-on goes through DEAD; turn-offs wait for MIN_ON.
        always_comb begin
            state_n    = state;
            dead_cnt_n = dead_cnt;
            on_cnt_n   = on_cnt;
            if (force_off) begin
                state_n    = S_OFF;
                dead_cnt_n = '0;
                on_cnt_n   = '0;
            end else begin
                case (state)
                    S_OFF: begin
                        if (req_hi || req_lo) begin
                            state_n    = S_DEAD;
                            dead_cnt_n = DT_LOAD;
                        end
                    end
                    S_DEAD: begin
                        if (dead_cnt <= CW'(1)) begin
                            dead_cnt_n = '0;
                            if (req_hi) begin
                                state_n  = S_HIGH;
                                on_cnt_n = CW'(1);
                            end else if (req_lo) begin
                                state_n  = S_LOW;
                                on_cnt_n = CW'(1);
                            end else begin
                                state_n = S_OFF;
                            end
                        end else begin
                            dead_cnt_n = dead_cnt - CW'(1);
                        end
                    end
                    S_HIGH: begin
                        if (!req_hi && (on_cnt >= ON_MIN)) begin
                            on_cnt_n = '0;
                            if (req_lo) begin
                                state_n    = S_DEAD;
                                dead_cnt_n = DT_LOAD;
                            end else begin
                                state_n = S_OFF;
                            end
                        end else if (on_cnt < ON_MIN) begin
                            on_cnt_n = on_cnt + CW'(1);
                        end
                    end
                    S_LOW: begin
                        if (!req_lo && (on_cnt >= ON_MIN)) begin
                            on_cnt_n = '0;
                            if (req_hi) begin
                                state_n    = S_DEAD;
                                dead_cnt_n = DT_LOAD;
                            end else begin
                                state_n = S_OFF;
                            end
                        end else if (on_cnt < ON_MIN) begin
                            on_cnt_n = on_cnt + CW'(1);
                        end
                    end
                    default: state_n = S_OFF;
                endcase
            end
        end

        // Gates are registered from the next state so they track the FSM edge.
        always_ff @(posedge CLK) begin
            if (RST) begin
                state    <= S_OFF;
                dead_cnt <= '0;
                on_cnt   <= '0;
                hi_q     <= 1'b0;
                lo_q     <= 1'b0;
            end else begin
                state    <= state_n;
                dead_cnt <= dead_cnt_n;
                on_cnt   <= on_cnt_n;
                hi_q     <= (state_n == S_HIGH);
                lo_q     <= (state_n == S_LOW);
            end
        end

        assign gate_hi[l] = hi_q;
        assign gate_lo[l] = lo_q;
    end

    assign {G_3, G_2, G_1} = gate_hi;
    assign {G_6, G_5, G_4} = gate_lo;

endmodule

// File: tb/tb_svpwm_deadtime.sv
// Bench for svpwm_deadtime: two instances (10/4 and 3/1) share stimulus and are
// compared each cycle against a cycle model through a scoreboard queue.
module tb_svpwm_deadtime;

    localparam int M_OFF  = 0;
    localparam int M_DEAD = 1;
    localparam int M_HIGH = 2;
    localparam int M_LOW  = 3;
    localparam int HMAX   = 4096;

    typedef logic [9:0] obs_t;

    logic       clk;
    logic       rst;
    logic [5:0] t;
    logic       fault;
    logic       fault_clr;
    logic [5:0] g_a;
    logic [5:0] g_b;
    logic       fl_a;
    logic       fl_b;
    logic [2:0] se_a;
    logic [2:0] se_b;

    int n_vec  = 0;
    int n_miss = 0;
    int sc     = 0;

    int         dtv[2] = '{10, 3};
    int         mov[2] = '{4, 1};
    int         m_st[2][3];
    int         m_dc[2][3];
    int         m_oc[2][3];
    logic       m_fl[2];
    logic [2:0] m_se[2];
    logic [5:0] m_g[2];
    logic [5:0] m_cmd;
    logic       m_flt;
    logic       m_clr;
    logic [5:0] hist[HMAX];
    obs_t       sb_a[$];
    obs_t       sb_b[$];
    int         duty_tbl[12] = '{16, 21, 24, 26, 24, 21, 16, 11, 8, 6, 8, 11};

    svpwm_deadtime #(.DEADTIME(10), .MIN_ON(4)) u_dut_a (
        .CLK(clk), .RST(rst),
        .T_1(t[0]), .T_2(t[1]), .T_3(t[2]), .T_4(t[3]), .T_5(t[4]), .T_6(t[5]),
        .FAULT(fault), .FAULT_CLR(fault_clr),
        .G_1(g_a[0]), .G_2(g_a[1]), .G_3(g_a[2]), .G_4(g_a[3]), .G_5(g_a[4]), .G_6(g_a[5]),
        .FAULT_LATCHED(fl_a), .ST_ERR(se_a)
    );

    svpwm_deadtime #(.DEADTIME(3), .MIN_ON(1)) u_dut_b (
        .CLK(clk), .RST(rst),
        .T_1(t[0]), .T_2(t[1]), .T_3(t[2]), .T_4(t[3]), .T_5(t[4]), .T_6(t[5]),
        .FAULT(fault), .FAULT_CLR(fault_clr),
        .G_1(g_b[0]), .G_2(g_b[1]), .G_3(g_b[2]), .G_4(g_b[3]), .G_5(g_b[4]), .G_6(g_b[5]),
        .FAULT_LATCHED(fl_b), .ST_ERR(se_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", tag, act, exp, sc);
        end
    endtask

    // Reference behaviour of one clock edge for both parameter sets.
    task automatic model_edge();
        logic [2:0] up;
        logic [2:0] lo;
        logic [2:0] sh;
        logic       fs;
        logic       ok;
        logic       wh;
        logic       wl;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_fl[i] = 1'b0;
                m_se[i] = 3'b000;
                m_g[i]  = 6'b0;
                for (int l = 0; l < 3; l++) begin
                    m_st[i][l] = M_OFF;
                    m_dc[i][l] = 0;
                    m_oc[i][l] = 0;
                end
            end
            m_cmd = 6'b0;
            m_flt = 1'b0;
            m_clr = 1'b0;
        end else begin
            up = m_cmd[2:0];
            lo = m_cmd[5:3];
            sh = up & lo;
            fs = m_flt || (sh != 3'b000);
            ok = m_clr && !fs;
            for (int i = 0; i < 2; i++) begin
                for (int l = 0; l < 3; l++) begin
                    wh = up[l] && !lo[l];
                    wl = lo[l] && !up[l];
                    if (m_fl[i] || fs) begin
                        m_st[i][l] = M_OFF;
                        m_dc[i][l] = 0;
                        m_oc[i][l] = 0;
                    end else if (m_st[i][l] == M_OFF) begin
                        if (wh || wl) begin
                            m_st[i][l] = M_DEAD;
                            m_dc[i][l] = dtv[i];
                        end
                    end else if (m_st[i][l] == M_DEAD) begin
                        m_dc[i][l]--;
                        if (m_dc[i][l] == 0) begin
                            m_st[i][l] = wh ? M_HIGH : (wl ? M_LOW : M_OFF);
                            m_oc[i][l] = (m_st[i][l] == M_OFF) ? 0 : 1;
                        end
                    end else begin
                        if (((m_st[i][l] == M_HIGH) ? !wh : !wl) && m_oc[i][l] >= mov[i]) begin
                            m_oc[i][l] = 0;
                            if ((m_st[i][l] == M_HIGH) ? wl : wh) begin
                                m_st[i][l] = M_DEAD;
                                m_dc[i][l] = dtv[i];
                            end else begin
                                m_st[i][l] = M_OFF;
                            end
                        end else if (m_oc[i][l] < mov[i]) begin
                            m_oc[i][l]++;
                        end
                    end
                    m_g[i][l]   = (m_st[i][l] == M_HIGH);
                    m_g[i][l+3] = (m_st[i][l] == M_LOW);
                end
                if (fs) m_fl[i] = 1'b1;
                else if (ok) m_fl[i] = 1'b0;
                m_se[i] = ok ? 3'b000 : (m_se[i] | sh);
            end
            m_cmd = t;
            m_flt = fault;
            m_clr = fault_clr;
        end
    endtask

    task automatic step();
        obs_t ea;
        obs_t eb;
        model_edge();
        sb_a.push_back({m_g[0], m_fl[0], m_se[0]});
        sb_b.push_back({m_g[1], m_fl[1], m_se[1]});
        if (sc < HMAX) hist[sc] = t;
        @(posedge clk);
        #1;
        ea = sb_a.pop_front();
        eb = sb_b.pop_front();
        check("sb_a", 32'({g_a, fl_a, se_a}), 32'(ea));
        check("sb_b", 32'({g_b, fl_b, se_b}), 32'(eb));
        check("overlap_a", 32'(g_a[2:0] & g_a[5:3]), 32'(0));
        check("overlap_b", 32'(g_b[2:0] & g_b[5:3]), 32'(0));
        sc++;
    endtask

    task automatic wait_level(input int idx, input logic lvl, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (g_a[idx] !== lvl && n < limit);
    endtask

    initial begin
        int         n;
        logic [5:0] prev;
        int         k;
        int         pos;
        rst       = 1'b1;
        t         = 6'b0;
        fault     = 1'b0;
        fault_clr = 1'b0;
        step();
        step();
        check("rst_g", 32'(g_a), 32'(0));
        check("rst_fl", 32'(fl_a), 32'(0));
        check("rst_se", 32'(se_a), 32'(0));
        rst = 1'b0;

        // Leg A turn-on latency and HIGH->LOW swap.
        t = 6'b000001;
        wait_level(0, 1'b1, 40, n);
        check("g1_rise_lat", 32'(n), 32'(12));
        check("g4_idle", 32'(g_a[3]), 32'(0));
        repeat (38) step();
        t = 6'b001000;
        wait_level(0, 1'b0, 10, n);
        check("g1_fall_lat", 32'(n), 32'(2));
        wait_level(3, 1'b1, 40, n);
        check("g4_dead_gap", 32'(n), 32'(10));

        // Leg B minimum on-time.
        t = 6'b000010;
        wait_level(1, 1'b1, 40, n);
        check("g2_rise_lat", 32'(n), 32'(12));
        t = 6'b010000;
        wait_level(1, 1'b0, 20, n);
        check("g2_on_width", 32'(n), 32'(4));
        wait_level(4, 1'b1, 40, n);
        check("g5_dead_gap", 32'(n), 32'(10));

        // Shoot-through on leg C.
        t = 6'b100100;
        step();
        t = 6'b000100;
        step();
        check("st_fl", 32'(fl_a), 32'(1));
        check("st_err", 32'(se_a), 32'(3'b100));
        check("st_gates", 32'(g_a), 32'(0));
        repeat (20) step();
        check("st_hold_gates", 32'(g_a), 32'(0));
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        wait_level(2, 1'b1, 40, n);
        check("st_recover_lat", 32'(n), 32'(12));
        check("st_cleared", 32'({fl_a, se_a}), 32'(0));

        // External fault during leg C dead time.
        t = 6'b000000;
        repeat (5) step();
        t = 6'b100000;
        repeat (4) step();
        fault = 1'b1;
        step();
        step();
        check("flt_latched", 32'(fl_a), 32'(1));
        check("flt_gates", 32'(g_a), 32'(0));
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        repeat (3) step();
        check("flt_clr_ignored", 32'(fl_a), 32'(1));
        fault = 1'b0;
        repeat (3) step();
        check("flt_sticky", 32'(fl_a), 32'(1));
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        wait_level(5, 1'b1, 40, n);
        check("flt_recover_lat", 32'(n), 32'(12));
        check("flt_cleared", 32'(fl_a), 32'(0));

        // Carrier-based complementary pattern; instance B edges checked against commands.
        t = 6'b0;
        repeat (20) step();
        for (int c = 0; c < 2000; c++) begin
            pos = c % 32;
            for (int l = 0; l < 3; l++) begin
                k        = (c / 32 + 4 * l) % 12;
                t[l]     = (pos < duty_tbl[k]);
                t[l + 3] = !(pos < duty_tbl[k]);
            end
            prev = g_b;
            step();
            n = sc - 1;
            if (n >= 5 && n < HMAX) begin
                for (int j = 0; j < 6; j++) begin
                    if (g_b[j] && !prev[j])
                        check("edge_rise_b", 32'({hist[n-4][j], hist[n-5][j]}), 32'(2'b10));
                    if (!g_b[j] && prev[j])
                        check("edge_fall_b", 32'({hist[n-1][j], hist[n-2][j]}), 32'(2'b01));
                end
            end
        end

        // Reset while switching drops every gate immediately.
        rst = 1'b1;
        step();
        check("midrst_g_a", 32'(g_a), 32'(0));
        check("midrst_g_b", 32'(g_b), 32'(0));
        rst = 1'b0;
        t   = 6'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
